// File: rtl/avg_filter_pkg.sv
// Shared constants and width derivations for the moving-average filter.
package avg_filter_pkg;

  localparam int unsigned ROUND_TRUNC   = 0;
  localparam int unsigned ROUND_HALF_UP = 1;

  function automatic int unsigned depth_of(input int unsigned log2_depth);
    return 32'd1 << log2_depth;
  endfunction

  // DEPTH samples of DATA_WIDTH bits cannot exceed DATA_WIDTH+LOG2_DEPTH bits.
  function automatic int unsigned sum_width(input int unsigned data_width,
                                            input int unsigned log2_depth);
    return data_width + log2_depth;
  endfunction

  // Half of one output LSB in sum units; zero when the window is one sample.
  function automatic int unsigned half_lsb(input int unsigned log2_depth);
    return (32'd1 << log2_depth) >> 1;
  endfunction

endpackage

// File: rtl/mavg_delay_line.sv
// Circular sample store; oldest_c is the entry about to be overwritten.
module mavg_delay_line
  import avg_filter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LOG2_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] oldest_c
);

  localparam int unsigned DEPTH = depth_of(LOG2_DEPTH);

  generate
    if (LOG2_DEPTH == 0) begin : g_single
      logic [DATA_WIDTH-1:0] entry;
      logic                  unused_ok;

      // Single entry: the pointer is always zero.
      assign unused_ok = reset ^ clear;

      always_ff @(posedge clk) begin
        if (we) entry <= din;
      end

      assign oldest_c = entry;
    end else begin : g_ring
      logic [DATA_WIDTH-1:0] mem [DEPTH];
      logic [LOG2_DEPTH-1:0] ptr;

      // Natural binary overflow gives the DEPTH-1 -> 0 wrap.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          ptr <= '0;
        end else if (clear) begin
          ptr <= '0;
        end else if (we) begin
          ptr <= ptr + LOG2_DEPTH'(1);
        end
      end

      // Storage is not reset; stale entries are masked by the fill count.
      always_ff @(posedge clk) begin
        if (we) mem[ptr] <= din;
      end

      assign oldest_c = mem[ptr];
    end
  endgenerate

endmodule

// File: rtl/moving_average_filter.sv
// Running-sum moving average over the last 2**LOG2_DEPTH samples, one-cycle latency.
module moving_average_filter
  import avg_filter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LOG2_DEPTH = 3,
  parameter int unsigned ROUND      = ROUND_TRUNC
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_clear,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_full
);

  localparam int unsigned DEPTH  = depth_of(LOG2_DEPTH);
  localparam int unsigned SUM_W  = sum_width(DATA_WIDTH, LOG2_DEPTH);
  localparam int unsigned RND_W  = SUM_W + 1;
  localparam int unsigned FILL_W = LOG2_DEPTH + 1;
  localparam int unsigned HALF   = (ROUND == ROUND_HALF_UP) ? half_lsb(LOG2_DEPTH) : 0;

  logic                  accept;
  logic                  full;
  logic [DATA_WIDTH-1:0] oldest_c;
  logic [DATA_WIDTH-1:0] oldest_used;
  logic [SUM_W-1:0]      sum;
  logic [SUM_W-1:0]      sum_next;
  logic [RND_W-1:0]      rounded;
  logic [DATA_WIDTH-1:0] avg_next;
  logic [FILL_W-1:0]     fill;
  logic [FILL_W-1:0]     fill_next;

  assign accept = i_valid & ~i_clear;
  assign full   = (fill == FILL_W'(DEPTH));

  mavg_delay_line #(
    .DATA_WIDTH (DATA_WIDTH),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_delay_line (
    .clk      (i_clk),
    .reset    (i_reset),
    .we       (accept),
    .clear    (i_clear),
    .din      (i_data),
    .oldest_c (oldest_c)
  );

  // Until the window is full the departing sample counts as zero.
  always_comb begin
    oldest_used = full ? oldest_c : '0;
    sum_next    = sum + SUM_W'(i_data) - SUM_W'(oldest_used);
    fill_next   = full ? fill : fill + FILL_W'(1);
    rounded     = RND_W'(sum_next) + RND_W'(HALF);
    avg_next    = DATA_WIDTH'(rounded >> LOG2_DEPTH);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sum     <= '0;
      fill    <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_full  <= 1'b0;
    end else if (i_clear) begin
      sum     <= '0;
      fill    <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_full  <= 1'b0;
    end else if (accept) begin
      sum     <= sum_next;
      fill    <= fill_next;
      o_data  <= avg_next;
      o_valid <= 1'b1;
      o_full  <= (fill_next == FILL_W'(DEPTH));
    end else begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_moving_average_filter.sv
// Self-checking bench: directed table, corner sequences and random traffic vs. a window model.
module tb_moving_average_filter;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic       clear;
  logic [7:0] data;

  logic       t_valid, r_valid, p_valid;
  logic [7:0] t_data,  r_data,  p_data;
  logic       t_full,  r_full,  p_full;

  int checks = 0;
  int errors = 0;

  int   hist[$];
  int   exp_data[3];
  bit   exp_valid;

  always #5 clk = ~clk;

  // Truncating window of 4.
  moving_average_filter #(.DATA_WIDTH(8), .LOG2_DEPTH(2), .ROUND(0)) dut_t (
    .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_data(data), .i_clear(clear),
    .o_valid(t_valid), .o_data(t_data), .o_full(t_full));

  // Rounding window of 4.
  moving_average_filter #(.DATA_WIDTH(8), .LOG2_DEPTH(2), .ROUND(1)) dut_r (
    .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_data(data), .i_clear(clear),
    .o_valid(r_valid), .o_data(r_data), .o_full(r_full));

  // Single-sample window: pass-through, rounding must have no effect.
  moving_average_filter #(.DATA_WIDTH(8), .LOG2_DEPTH(0), .ROUND(1)) dut_p (
    .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_data(data), .i_clear(clear),
    .o_valid(p_valid), .o_data(p_data), .o_full(p_full));

  typedef struct {
    bit v;
    bit c;
    int d;
    int ed;
    bit ev;
    bit ef;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit v, bit c, int d, int ed, bit ev, bit ef);
    vec_t r;
    r.v = v; r.c = c; r.d = d; r.ed = ed; r.ev = ev; r.ef = ef;
    return r;
  endfunction

  // Average of the most recent window, missing samples taken as zero.
  function automatic int model_avg(int l2d, bit rnd);
    int depth = 1 << l2d;
    int n     = hist.size();
    int s     = 0;
    for (int i = 0; i < depth && i < n; i++) s += hist[n - 1 - i];
    if (rnd && l2d > 0) s += depth / 2;
    return s >> l2d;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    exp_valid = 1'b0;
    for (int i = 0; i < 3; i++) exp_data[i] = 0;
  endtask

  task automatic check_all();
    chk("t_data",  int'(t_data),  exp_data[0]);
    chk("r_data",  int'(r_data),  exp_data[1]);
    chk("p_data",  int'(p_data),  exp_data[2]);
    chk("t_valid", int'(t_valid), int'(exp_valid));
    chk("r_valid", int'(r_valid), int'(exp_valid));
    chk("p_valid", int'(p_valid), int'(exp_valid));
    chk("t_full",  int'(t_full),  int'(hist.size() >= 4));
    chk("r_full",  int'(r_full),  int'(hist.size() >= 4));
    chk("p_full",  int'(p_full),  int'(hist.size() >= 1));
  endtask

  task automatic step(input bit v, input bit c, input int d);
    @(negedge clk);
    valid = v;
    clear = c;
    data  = 8'(d);
    @(posedge clk);
    #1;
    if (c) begin
      model_reset();
    end else if (v) begin
      hist.push_back(d);
      if (hist.size() > 256) void'(hist.pop_front());
      exp_valid   = 1'b1;
      exp_data[0] = model_avg(2, 1'b0);
      exp_data[1] = model_avg(2, 1'b1);
      exp_data[2] = model_avg(0, 1'b1);
    end else begin
      exp_valid = 1'b0;
    end
    check_all();
  endtask

  int rnd_exp[3];
  int trn_exp[3];

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    clear = 1'b0;
    data  = '0;
    model_reset();

    // Outputs held at zero while reset is asserted.
    #12;
    chk("rst_data",  int'(t_data),  0);
    chk("rst_valid", int'(t_valid), 0);
    chk("rst_full",  int'(t_full),  0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0);

    // Directed vectors for the truncating window of 4.
    tbl.push_back(mk(0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 4, 1, 1, 0));
    tbl.push_back(mk(1, 0, 8, 3, 1, 0));
    tbl.push_back(mk(1, 0, 12, 6, 1, 0));
    tbl.push_back(mk(1, 0, 16, 10, 1, 1));
    tbl.push_back(mk(1, 0, 20, 14, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 255, 63, 1, 0));
    tbl.push_back(mk(1, 0, 255, 127, 1, 0));
    tbl.push_back(mk(1, 0, 255, 191, 1, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 0, 255, 255, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 4, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 8, 3, 1, 0));
    tbl.push_back(mk(1, 1, 100, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8, 2, 1, 0));

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].c, tbl[i].d);
      chk($sformatf("tbl%0d_data", i),  int'(t_data),  tbl[i].ed);
      chk($sformatf("tbl%0d_valid", i), int'(t_valid), int'(tbl[i].ev));
      chk($sformatf("tbl%0d_full", i),  int'(t_full),  int'(tbl[i].ef));
    end

    // Rounding: 1,1,1 gives 0,1,1 rounded and 0,0,0 truncated.
    rnd_exp = '{0, 1, 1};
    trn_exp = '{0, 0, 0};
    step(1'b0, 1'b1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1);
      chk($sformatf("round%0d", i), int'(r_data), rnd_exp[i]);
      chk($sformatf("trunc%0d", i), int'(t_data), trn_exp[i]);
    end

    // Asynchronous reset between edges after three samples.
    step(1'b0, 1'b1, 0);
    step(1'b1, 1'b0, 10);
    step(1'b1, 1'b0, 20);
    step(1'b1, 1'b0, 30);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_data",  int'(t_data),  0);
    chk("arst_valid", int'(t_valid), 0);
    chk("arst_full",  int'(t_full),  0);
    chk("arst_pdata", int'(p_data),  0);
    #1;
    rst = 1'b0;
    model_reset();
    step(1'b1, 1'b0, 40);
    chk("post_rst_data", int'(t_data), 10);
    chk("post_rst_full", int'(t_full), 0);

    // Random traffic against the window model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(99, 0) < 70, $urandom_range(99, 0) < 3, int'($urandom_range(255, 0)));
    end
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
